// File: rtl/alu_cmd_sequencer.sv
// Command front-end for an external combinational ALU: buffers commands in a FIFO, issues them
// on registered operand outputs and returns captured results on a valid/ready response channel.
module alu_cmd_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [2:0]       cmd_op_i,
  input  logic             cmd_src_acc_i,
  input  logic [WIDTH-1:0] cmd_a_i,
  input  logic [WIDTH-1:0] cmd_b_i,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [2:0]       alu_opcode_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_carry_i,
  input  logic             alu_zero_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic             rsp_carry_o,
  output logic             rsp_zero_o,
  output logic             rsp_illegal_o,
  output logic [WIDTH-1:0] acc_o,
  output logic             busy_o
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam int unsigned EntryW = 4 + 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            state_q, state_d;
  logic [EntryW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              push, pop;

  logic [EntryW-1:0] head;
  logic [2:0]        head_op;
  logic              head_src;
  logic [WIDTH-1:0]  head_a, head_b;

  logic [WIDTH-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d, acc_q, acc_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [WIDTH-1:0]  rsp_result_q, rsp_result_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_carry_q, rsp_carry_d;
  logic              rsp_zero_q, rsp_zero_d, rsp_illegal_q, rsp_illegal_d;

  // Entry layout: {op, src_acc, a, b}
  assign head     = mem_q[rd_ptr_q];
  assign head_op  = head[EntryW-1 -: 3];
  assign head_src = head[2*WIDTH];
  assign head_a   = head[2*WIDTH-1 -: WIDTH];
  assign head_b   = head[WIDTH-1:0];

  assign cmd_ready_o = (cnt_q < CntW'(DEPTH));
  assign push        = cmd_valid_i && cmd_ready_o;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_op_i, cmd_src_acc_i, cmd_a_i, cmd_b_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    acc_d         = acc_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_carry_d   = rsp_carry_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_illegal_d = rsp_illegal_q;

    unique case (state_q)
      StIdle: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        rsp_result_d  = alu_result_i;
        rsp_carry_d   = alu_carry_i;
        rsp_zero_d    = alu_zero_i;
        rsp_illegal_d = (alu_op_q >= 3'b101);
        acc_d         = alu_result_i;
        rsp_valid_d   = 1'b1;
        state_d       = StResp;
      end
      StResp: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          // Back-to-back issue avoids an IDLE bubble between responses
          if (cnt_q != '0) begin
            pop     = 1'b1;
            state_d = StExec;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (pop) begin
      alu_op_d = head_op;
      alu_b_d  = head_b;
      alu_a_d  = head_src ? acc_q : head_a;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      acc_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_carry_q   <= 1'b0;
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      acc_q         <= acc_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_carry_q   <= rsp_carry_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign alu_opcode_o  = alu_op_q;
  assign acc_o         = acc_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_result_o  = rsp_result_q;
  assign rsp_carry_o   = rsp_carry_q;
  assign rsp_zero_o    = rsp_zero_q;
  assign rsp_illegal_o = rsp_illegal_q;
  assign busy_o        = (state_q != StIdle) || (cnt_q != '0);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: stand-in ALU, directed scenarios and a random phase checked
// against an in-order response model.
module tb_alu_cmd_sequencer;

  localparam int unsigned W = 4;

  logic         clk, rst_n;
  logic         cmd_valid, cmd_ready, cmd_src_acc;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_a, cmd_b;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_opcode;
  logic         alu_carry, alu_zero;
  logic         rsp_valid, rsp_ready, rsp_carry, rsp_zero, rsp_illegal, busy;
  logic [W-1:0] rsp_result, acc;

  typedef struct packed {
    logic         illegal;
    logic         zero;
    logic         carry;
    logic [W-1:0] result;
  } rsp_t;

  rsp_t   exp_q[$];
  int     checks = 0;
  int     failures = 0;
  int     model_acc = 0;
  bit     rnd_ready = 0;
  int     w;

  alu_cmd_sequencer #(.WIDTH(W), .DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_src_acc_i(cmd_src_acc), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_opcode_o(alu_opcode),
    .alu_result_i(alu_result), .alu_carry_i(alu_carry), .alu_zero_i(alu_zero),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .rsp_carry_o(rsp_carry), .rsp_zero_o(rsp_zero), .rsp_illegal_o(rsp_illegal),
    .acc_o(acc), .busy_o(busy)
  );

  // Stand-in for the external 4-bit ALU
  logic [W:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    case (alu_opcode)
      3'd0:    alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1:    alu_sum = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2:    alu_sum = {1'b0, alu_a & alu_b};
      3'd3:    alu_sum = {1'b0, alu_a | alu_b};
      3'd4:    alu_sum = {1'b0, ~alu_a};
      default: alu_sum = '0;
    endcase
    alu_result = alu_sum[W-1:0];
    alu_carry  = alu_sum[W];
    alu_zero   = (alu_sum[W-1:0] == '0);
  end

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic rsp_t ref_op(input int op, input int a, input int b);
    rsp_t r;
    int   v;
    r.carry   = 1'b0;
    r.illegal = 1'b0;
    case (op)
      0:       begin v = a + b; r.carry = (v > 15); end
      1:       begin v = a - b; r.carry = (a < b); end
      2:       v = a & b;
      3:       v = a | b;
      4:       v = 15 - a;
      default: begin v = 0; r.illegal = 1'b1; end
    endcase
    v        = v & 15;
    r.result = 4'(v);
    r.zero   = (v == 0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every held response must match the oldest outstanding prediction
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_rsp", 32'(rsp_valid), 0);
      end else begin
        check("rsp_result", 32'(rsp_result), 32'(exp_q[0].result));
        check("rsp_flags", {29'd0, rsp_illegal, rsp_zero, rsp_carry},
              {29'd0, exp_q[0].illegal, exp_q[0].zero, exp_q[0].carry});
        check("acc", 32'(acc), 32'(exp_q[0].result));
        if (rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic push(input logic [2:0] op, input logic src, input logic [W-1:0] a,
                      input logic [W-1:0] b, output int waits);
    rsp_t e;
    bit   acc_ok;
    waits       = 0;
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_src_acc = src;
    cmd_a       = a;
    cmd_b       = b;
    acc_ok      = 0;
    while (!acc_ok && waits < 300) begin
      @(negedge clk);
      acc_ok = cmd_ready;
      if (acc_ok) begin
        e = ref_op(int'(op), src ? model_acc : int'(a), int'(b));
        model_acc = int'(e.result);
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      if (rnd_ready) rsp_ready = 1'($urandom_range(0, 1));
      if (!acc_ok) waits++;
    end
    if (!acc_ok) check("push_timeout", 0, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    rsp_ready = 1'b1;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, 32'(exp_q.size() == 0 && !busy), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; cmd_valid = 0; cmd_op = '0; cmd_src_acc = 0; cmd_a = '0; cmd_b = '0;
    rsp_ready = 0;
    #12;
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_acc", 32'(acc), 0);
    check("rst_alu", {21'd0, alu_opcode, alu_a, alu_b}, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Add with carry and first-response latency
    rsp_ready = 1;
    push(3'd0, 0, 4'd9, 4'd8, w);
    @(negedge clk); check("lat_e0", 32'(rsp_valid), 0);
    @(negedge clk); check("lat_e1", 32'(rsp_valid), 0); check("lat_busy", 32'(busy), 1);
    @(negedge clk); check("lat_e2", 32'(rsp_valid), 1);
    drain("add");
    check("add_acc", 32'(acc), 1);

    push(3'd1, 0, 4'd3, 4'd5, w);
    drain("sub");
    check("sub_acc", 32'(acc), 14);

    // Accumulator chain, back-to-back
    push(3'd0, 0, 4'd3, 4'd4, w);
    push(3'd1, 1, 4'd0, 4'd7, w);
    @(negedge clk); check("chain_e2", 32'(rsp_valid), 0);
    @(negedge clk); check("chain_rsp1", 32'(rsp_valid), 1);
    @(negedge clk); check("chain_gap", 32'(rsp_valid), 0); check("chain_alu_a", 32'(alu_a), 7);
    @(negedge clk); check("chain_rsp2", 32'(rsp_valid), 1);
    drain("chain");

    // Backpressure fills the FIFO
    rsp_ready = 0;
    for (int i = 0; i < 5; i++) begin
      push(3'(i % 4), 0, 4'(3 * i + 1), 4'(i + 2), w);
      check("bp_accept_wait", 32'(w), 0);
    end
    @(negedge clk); check("bp_full", 32'(cmd_ready), 0);
    cmd_valid = 1; cmd_op = 3'd2; cmd_a = 4'hc; cmd_b = 4'ha;
    repeat (3) begin
      @(negedge clk);
      check("bp_stall_ready", 32'(cmd_ready), 0);
      check("bp_stall_valid", 32'(rsp_valid), 1);
    end
    @(posedge clk); #1; rsp_ready = 1;
    @(negedge clk); check("bp_still_full", 32'(cmd_ready), 0);
    push(3'd2, 0, 4'hc, 4'ha, w);
    check("bp_ready_after_pop", 32'(w), 0);
    drain("bp");

    // Illegal opcode then NOT A
    push(3'd6, 0, 4'hf, 4'hf, w);
    push(3'd4, 0, 4'b0101, 4'd0, w);
    drain("illegal");
    check("not_acc", 32'(acc), 32'hA);

    // Reset during EXEC with commands queued
    push(3'd0, 0, 4'd1, 4'd2, w);
    push(3'd0, 0, 4'd3, 4'd4, w);
    push(3'd0, 0, 4'd5, 4'd6, w);
    @(posedge clk); #1;
    rst_n = 0;
    exp_q.delete();
    model_acc = 0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 0);
    check("mid_rst_acc", 32'(acc), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ready", 32'(cmd_ready), 1);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    repeat (6) @(negedge clk);
    check("post_rst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    push(3'd0, 0, 4'd1, 4'd1, w);
    drain("post_rst");
    check("post_rst_acc", 32'(acc), 2);

    // Random commands with random response backpressure
    rnd_ready = 1;
    for (int i = 0; i < 80; i++) begin
      push(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 4'($urandom),
           4'($urandom), w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
    rnd_ready = 0;
    drain("random");
    check("end_ready", 32'(cmd_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
